// File: rtl/rc5_encrypt_core.sv
// RC5-32/12/16 block encryption core: one 64-bit block per 28-cycle transaction,
// reading the expanded key table S through a synchronous-read RAM port.
module rc5_encrypt_core #(
  parameter int unsigned W     = 32,
  parameter int unsigned R     = 12,
  parameter int unsigned T     = 2 * (R + 1),
  parameter int unsigned T_LEN = $clog2(T)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_ready,
  input  logic               start,
  input  logic [2*W-1:0]     pt,
  output logic               ready,
  output logic [T_LEN-1:0]   s_addr,
  input  logic [W-1:0]       s_rdata,
  output logic [2*W-1:0]     ct,
  output logic               done
);

  localparam int unsigned SH = $clog2(W);
  localparam logic [T_LEN-1:0] J_LAST = T_LEN'(T - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [T_LEN-1:0]   j_q, j_d;
  logic [2*W-1:0]     ct_q, ct_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic [T_LEN-1:0]   s_addr_q, s_addr_d;
  logic [W-1:0]       a_step, b_step;

  // Left rotate by the low SH bits; the doubled word makes a zero amount an identity.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [SH-1:0] n);
    logic [2*W-1:0] d;
    d = {x, x} << n;
    return d[2*W-1:W];
  endfunction

  // Half-round results for the current step; s_rdata holds S[j] here.
  always_comb begin
    a_step = (j_q == '0) ? a_q + s_rdata
                         : rotl(a_q ^ b_q, b_q[SH-1:0]) + s_rdata;
    b_step = (j_q == T_LEN'(1)) ? b_q + s_rdata
                                : rotl(b_q ^ a_q, a_q[SH-1:0]) + s_rdata;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    j_d      = j_q;
    ct_d     = ct_q;
    done_d   = 1'b0;
    ready_d  = 1'b0;
    s_addr_d = '0;

    case (state_q)
      IDLE: begin
        if (start && key_ready) begin
          a_d     = pt[W-1:0];
          b_d     = pt[2*W-1:W];
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!key_ready) begin
          state_d = IDLE;
        end else begin
          if (j_q[0]) b_d = b_step;
          else        a_d = a_step;
          j_d = j_q + 1'b1;
          if (j_q == J_LAST) begin
            ct_d    = {b_step, a_q};
            done_d  = 1'b1;
            j_d     = '0;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs are derived from the state being entered.
    ready_d = (state_d == IDLE);
    if (state_d == RUN && j_d != J_LAST) s_addr_d = j_d + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      j_q      <= '0;
      ct_q     <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      s_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      j_q      <= j_d;
      ct_q     <= ct_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      s_addr_q <= s_addr_d;
    end
  end

  assign ready  = ready_q;
  assign s_addr = s_addr_q;
  assign ct     = ct_q;
  assign done   = done_q;

endmodule

// File: doc/rc5_encrypt_core.md
# rc5_encrypt_core

Downstream consumer of the RC5-32/12/16 key expander. Encrypts one 64-bit plaintext block using the 26-word expanded key table S. S is held in the expander's S RAM, and this block reads it through a synchronous read port. The core starts only when the expander signals the table is complete. It produces one ciphertext block per 28-cycle transaction.

## Interface
- `W`, 32: word width in bits.
- `R`, 12: number of rounds.
- `T`, 2*(`R`+1) = 26: S table depth.
- `T_LEN`, 5: S address width, $clog2(`T`).
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, synchronous, active-high. One clock; all state changes on `clk` rising edge.
- `key_ready` input 1: high while S RAM holds a complete expanded table.
- `start` input 1: request to encrypt `pt`.
- `pt` input 64: plaintext. A = `pt`[31:0], B = `pt`[63:32].
- `ready` output 1: core idle and able to accept `start`.
- `s_addr` output `T_LEN`: S RAM read address.
- `s_rdata` input `W`: S RAM read data, valid the cycle after `s_addr` is presented.
- `ct` output 64: ciphertext. A = `ct`[31:0], B = `ct`[63:32].
- `done` output 1: one-cycle pulse, `ct` valid.

## Operation
- **States:** IDLE, RUN, DONE. Registers: A, B (32 each); step counter `j` (5 bits, 0..25); `ct`; `done`.
- **IDLE:**
  - `ready`=1, `s_addr`=0.
  - If `start` && `key_ready`: latch A/B from `pt`, clear `j`=0, go to RUN.
  - `start` without `key_ready` is ignored. `ready` stays 1 and nothing is latched.
- **RUN:**
  - `ready`=0.
  - `s_addr` = `j`+1, except `j`=25 where `s_addr`=0. `s_rdata` equals S[`j`].
  - Step `j`=0: A <= A + S[0].
  - Step `j`=1: B <= B + S[1].
  - Step `j` even, ≥2: A <= rotl(A^B, B[4:0]) + S[`j`].
  - Step `j` odd, ≥3: B <= rotl(B^A, A[4:0]) + S[`j`]. A here is the value written on the previous step.
  - All additions are mod 2^32. Rotation amount is the low 5 bits only; rotation by 0 is identity.
  - `j` increments each cycle. After step 25, `ct` <= {B_new, A}, `done` <= 1, go to DONE.
- **DONE:** `done`=1 for this single cycle, `ready`=0, `s_addr`=0. Next state is IDLE unconditionally. `start` in DONE is ignored.
- **`ct`:** holds the last result until the next completed transaction. It is not cleared on `start`.
- **`key_ready` falling during RUN:** abort to IDLE the next cycle. No `done`; `ct` is unchanged.
- **`rst`:** has priority in any state. Next cycle the core is in IDLE with `ready`=1, `done`=0, `ct`=0, A=B=0, `j`=0, `s_addr`=0. Reset mid-RUN discards the transaction with no `done`.

## Timing
- **Acceptance:** cycle 0, the edge where `start` && `key_ready` && `ready`. S[0] is addressed in cycle 0, since IDLE drives `s_addr`=0.
- **RUN:** cycles 1..26 (step `j` = cycle − 1).
- **Result:** `done`=1 and `ct` valid in cycle 27; `ready`=1 again in cycle 28.
- **Throughput:** one block per 28 cycles. Back-to-back `start` held high is accepted in cycle 28.
- **S RAM:** the core never issues `s_addr` ≥ 26. S RAM must not be written while `ready`=0.

## Test plan
- **Reset and basic handshake:** assert `rst` in any state, hold 1 cycle → `ready`=1, `done`=0, `ct`=0, `s_addr`=0. With S all zero, `pt`=0, start → `done` exactly 27 cycles after acceptance, `ct`=0, `s_addr` sequence 1..25, then 0.
- **RC5 vector 1:** S = expansion of key 00×16, `pt`=64'h0 → `ct`=64'h6D8F4B15_EEDBA521 (bytes 21A5DBEE154B8F6D).
- **RC5 vector 2:** S = expansion of key 915F4619BE41B2516355A50110A9CE91, `pt`=64'h6D8F4B15_EEDBA521 → `ct`=64'h52892B5B_AC13C0F7 (bytes F7C013AC5B2B8952).
- **Gating:** `start`=1 with `key_ready`=0 for 10 cycles → no state change, `ready` stays 1. Raise `key_ready` → accepted that cycle; `start` pulses during RUN/DONE are ignored.
- **Abort:** drop `key_ready` at RUN cycle 10 → IDLE next cycle, no `done`, `ct` retains the previous result. Assert `rst` at RUN cycle 15 of another transaction → no `done`, `ct`=0.
- **Back-to-back:** vector 1 then vector 2 with `start` held high → `done` pulses in cycles 27 and 55 with the respective correct `ct`.
